// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   DEF_N      : default operand width.
//   ST_*       : FSM state encodings (IDLE, RUN, DONE), also wrapped in state_e
//                so the debug state can be shown symbolically.
//   cnt_w(n)   : width of the step counter, clog2(n+1). The counter must hold
//                values 0..n.
package booth_pkg;

  localparam int DEF_N = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/result bus of the sequential Booth multiplier.
//   in_valid/in_ready         : operand handshake (source -> multiplier)
//   multiplicand/multiplier   : signed N-bit operands
//   out_valid/out_ready       : product handshake (multiplier -> consumer)
//   product                   : signed 2N-bit result
//   busy                      : high while an operation is in RUN or DONE
//   dbg_state                 : FSM state (booth_pkg::ST_* encoding)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. Once valid is raised, the sender holds
// valid and its data stable until that transfer. Ready never depends
// combinationally on valid, and valid never depends combinationally on ready.
interface booth_seq_mult_if #(parameter int N = 8);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;
  logic [1:0]     dbg_state;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy, dbg_state
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy, dbg_state
  );

endinterface

// File: rtl/booth.sv
// One combinational radix-2 Booth step on a W-bit accumulator.
//   a_i : accumulator A (W bits)
//   m_i : multiplicand M, already sign-extended to W bits
//   q_i : {multiplier Q, q(-1)} (W+1 bits)
//   a_o : A after add/subtract and arithmetic right shift
//   q_o : Q after the shift (receives the low bit of the updated A)
// Arithmetic is modulo 2^W.
module booth #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] m_i,
  input  logic [W:0]   q_i,
  output logic [W-1:0] a_o,
  output logic [W:0]   q_o
);

  logic [W-1:0] sum;

  always_comb begin
    // Q0,Q-1 = 01: end of a run of ones -> add M; 10: start of a run -> sub M.
    case (q_i[1:0])
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
    a_o = {sum[W-1], sum[W-1:1]};
    q_o = {sum[0], q_i[W:1]};
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed multiplier controller. Accepts an N x N two's-complement
// operand pair, runs N+1 Booth steps on an (N+1)-bit datapath, and returns
// the 2N-bit signed product.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : booth_seq_mult_if slave modport (operand/product handshakes,
//           busy, debug state)
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_seq_mult_if.slave   bus
);

  // One extra bit so that subtracting M = -2^(N-1) cannot overflow A.
  localparam int W  = N + 1;
  localparam int CW = cnt_w(N);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  m_q, m_d;
  logic [W:0]    q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  step_a;
  logic [W:0]    step_q;
  logic          accept;
  logic          last_step;

  booth #(.W(W)) u_step (
    .a_i (a_q),
    .m_i (m_q),
    .q_i (q_q),
    .a_o (step_a),
    .q_o (step_q)
  );

  assign accept    = bus.in_valid && (state_q == ST_IDLE);
  assign last_step = (cnt_q == CW'(N));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          a_d     = '0;
          m_d     = {bus.multiplicand[N-1], bus.multiplicand};
          q_d     = {bus.multiplier[N-1], bus.multiplier, 1'b0};
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d = step_a;
        q_d = step_q;
        // Counter stops at N so it never wraps; the step at count N is the last.
        if (last_step) state_d = ST_DONE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.dbg_state = state_q;
  // Low 2N bits of {A, Q[N+1:1]}; A and Q hold still in DONE, so the product
  // is stable until the output handshake.
  assign bus.product   = {a_q[N-2:0], q_q[W:1]};

endmodule

// File: tb/tb_booth_seq_mult.sv
module tb_booth_seq_mult;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mult_if #(.N(N)) bus ();

  booth_seq_mult #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2*N-1:0] exp_q[$];
  int rdy_mode = 0;      // 0: out_ready high, 1: random, 2: held low
  bit gap_mode = 1'b0;
  int last_hs  = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [2*N-1:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_product act=%h exp=none", bus.product);
      end else begin
        e = exp_q.pop_front();
        chk("product", 32'(bus.product), 32'(e));
      end
      if (gap_mode) begin
        if (last_hs >= 0) chk("transfer_gap", 32'(cyc - last_hs), 32'(N + 3));
        last_hs = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [N-1:0] m, input logic [N-1:0] q,
                      input logic [2*N-1:0] e, input bit push);
    int w;
    bus.in_valid     = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=in_ready_low exp=accept m=%h q=%h", m, q);
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d_pending exp=0", exp_q.size());
    end
  endtask

  // ---------------- directed vectors ----------------
  logic [N-1:0]   dv_m[8] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h07, 8'h7F, 8'h80, 8'h80};
  logic [N-1:0]   dv_q[8] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h06, 8'h7F, 8'h01, 8'h7F};
  logic [2*N-1:0] dv_e[8] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001,
                              16'h002A, 16'h3F01, 16'hFF80, 16'hC080};

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [N-1:0] rm, rq;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_busy",      32'(bus.busy), 32'd0);
    chk("reset_product",   32'(bus.product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3 x -5, latency
    send(8'h03, 8'hFB, 16'hFFF1, 1'b1);
    chk("busy_run",     32'(bus.busy), 32'd1);
    chk("in_ready_run", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency",   32'(lat), 32'd9);
    chk("state_done", 32'(bus.dbg_state), 32'd2);
    drain();

    // corners, back to back, with transfer spacing checked
    gap_mode = 1'b1;
    last_hs  = -1;
    for (int i = 0; i < 8; i++) send(dv_m[i], dv_q[i], dv_e[i], 1'b1);
    drain();
    gap_mode = 1'b0;

    // backpressure: product held, new operands not taken until handshake
    rdy_mode = 2;
    send(8'h05, 8'hF9, 16'hFFDD, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    fork
      send(8'h02, 8'h03, 16'h0006, 1'b1);
    join_none
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_product",   32'(bus.product), 32'h0000FFDD);
      chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_pending", 32'(exp_q.size()), 32'd1);
    rdy_mode = 0;
    wait fork;
    drain();

    // reset in the middle of RUN discards the operation
    send(8'h09, 8'h09, 16'h0051, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy",      32'(bus.busy), 32'd0);
    chk("midrst_product",   32'(bus.product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h07, 8'h06, 16'h002A, 1'b1);
    drain();

    // random operands with random out_ready throttling
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      rm = N'($urandom_range(0, 255));
      rq = N'($urandom_range(0, 255));
      send(rm, rq, (2*N)'($signed(rm) * $signed(rq)), 1'b1);
    end
    rdy_mode = 0;
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
